// File: rtl/rr_arbiter_2to4_pkg.sv
// Shared types and sizes for the four-way round-robin arbiter.
package rr_arbiter_2to4_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned HOLD_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/decoder_2_to_4_enable_2.sv
// Dataflow 2-to-4 decoder with enable; A is the index MSB, B the LSB.
module decoder_2_to_4_enable_2 (
    input  logic       EN,
    input  logic       A,
    input  logic       B,
    output logic [3:0] Q
);

    assign Q[0] = EN & ~A & ~B;
    assign Q[1] = EN & ~A &  B;
    assign Q[2] = EN &  A & ~B;
    assign Q[3] = EN &  A &  B;

endmodule

// File: rtl/rr_arbiter_2to4.sv
// Four-requester round-robin arbiter with optional hold-time preemption;
// the registered owner index is decoded into a one-hot grant.
module rr_arbiter_2to4
    import rr_arbiter_2to4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 gnt_valid
);

    localparam bit                PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = {HOLD_W{1'b1}};

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    last, last_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_d;
    logic                valid_d;

    logic [NUM_REQ-1:0]  owner_mask;
    logic [NUM_REQ-1:0]  others;
    logic [IDX_W-1:0]    pick_any;
    logic [IDX_W-1:0]    pick_other;

    // First set bit scanning base+1, base+2, ... wrapping; nearest candidate wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   base);
        logic [IDX_W-1:0] idx;
        rr_pick = base;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = base + IDX_W'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign owner_mask = NUM_REQ'(1) << idx_q;
    assign others     = req & ~owner_mask;
    assign pick_any   = rr_pick(req, last);
    assign pick_other = rr_pick(others, last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            last      <= 2'b11;
            hold_cnt  <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last      <= last_d;
            hold_cnt  <= hold_cnt_d;
            gnt_valid <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last;
        hold_cnt_d = hold_cnt;

        case (state_q)
            IDLE: begin
                if (en && (|req)) begin
                    state_d    = GRANT;
                    idx_d      = pick_any;
                    last_d     = pick_any;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (!req[idx_q]) begin
                    // Owner released: hand over without a bubble, or go idle.
                    if (|others) begin
                        idx_d      = pick_other;
                        last_d     = pick_other;
                        hold_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (PREEMPT_EN && (hold_cnt == HOLD_LAST) && (|others)) begin
                    idx_d      = pick_other;
                    last_d     = pick_other;
                    hold_cnt_d = '0;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == GRANT);
    end

    assign gnt_idx = idx_q;

    decoder_2_to_4_enable_2 u_dec (
        .EN (gnt_valid),
        .A  (idx_q[1]),
        .B  (idx_q[0]),
        .Q  (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_2to4.sv
// Directed bench for rr_arbiter_2to4: one instance with MAX_HOLD=3, one with preemption off.
module tb_rr_arbiter_2to4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] idx_a, idx_b;
    logic       valid_a, valid_b;

    int errors = 0;
    int checks = 0;

    rr_arbiter_2to4 #(.MAX_HOLD(3)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt_a),
        .gnt_idx   (idx_a),
        .gnt_valid (valid_a)
    );

    rr_arbiter_2to4 #(.MAX_HOLD(0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt_b),
        .gnt_idx   (idx_b),
        .gnt_valid (valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;

        // Reset state
        step();
        step();
        check("rst_gnt_a",   8'(gnt_a),          8'h00);
        check("rst_valid_a", 8'(valid_a),        8'h00);
        check("rst_idx_a",   8'(idx_a),          8'h00);
        check("rst_last_a",  8'(dut_a.last),     8'h03);
        check("rst_hold_a",  8'(dut_a.hold_cnt), 8'h00);
        check("rst_gnt_b",   8'(gnt_b),          8'h00);

        // Single request, one-cycle latency
        rst = 1'b0;
        en  = 1'b1;
        req = 4'b0100;
        step();
        check("single_gnt",   8'(gnt_a),   8'h04);
        check("single_idx",   8'(idx_a),   8'h02);
        check("single_valid", 8'(valid_a), 8'h01);

        // Owner 2 releases with nobody else waiting
        req = 4'b0000;
        step();
        check("release_gnt",   8'(gnt_a),   8'h00);
        check("release_valid", 8'(valid_a), 8'h00);
        check("release_state", 8'(dut_a.state_q), 8'h00);

        // last=2: scan 3,0,1 reaches requester 1 before 2
        req = 4'b0110;
        step();
        check("rescan_gnt", 8'(gnt_a), 8'h02);
        check("rescan_idx", 8'(idx_a), 8'h01);

        // Round-robin rotation on the no-preemption instance
        rst = 1'b1;
        step();
        check("rot_rst_gnt", 8'(gnt_b), 8'h00);
        rst = 1'b0;
        req = 4'b1111;
        step();
        check("rot_g0", 8'(gnt_b), 8'h01);
        req = 4'b1110;
        step();
        check("rot_g1", 8'(gnt_b), 8'h02);
        check("rot_v1", 8'(valid_b), 8'h01);
        req = 4'b1101;
        step();
        check("rot_g2", 8'(gnt_b), 8'h04);
        req = 4'b1011;
        step();
        check("rot_g3", 8'(gnt_b), 8'h08);
        req = 4'b0111;
        step();
        check("rot_g0_wrap", 8'(gnt_b), 8'h01);

        // MAX_HOLD=0 never preempts
        req = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            step();
            check("nohold_keep", 8'(gnt_b), 8'h01);
        end

        // Preemption every 3 cycles with two continuous requesters
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            step();
            check("preempt_seq", 8'(gnt_a), (((i / 3) % 2) == 0) ? 8'h01 : 8'h02);
        end

        // Sole requester keeps the grant while the counter saturates
        req = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            step();
            check("sole_keep", 8'(gnt_a), 8'h01);
        end
        check("hold_sat", dut_a.hold_cnt, 8'hFF);

        // Enable gating
        req = 4'b1000;
        step();
        check("en_pre_gnt", 8'(gnt_a), 8'h08);
        en = 1'b0;
        step();
        check("en_off_gnt",   8'(gnt_a),   8'h00);
        check("en_off_valid", 8'(valid_a), 8'h00);
        check("en_off_last",  8'(dut_a.last), 8'h03);
        en  = 1'b1;
        req = 4'b1001;
        step();
        check("en_on_gnt", 8'(gnt_a), 8'h01);

        // Reset pulse in the middle of a grant
        req = 4'b0100;
        step();
        check("mid_pre_gnt", 8'(gnt_a), 8'h04);
        rst = 1'b1;
        req = 4'b0101;
        step();
        check("mid_rst_gnt",   8'(gnt_a),   8'h00);
        check("mid_rst_valid", 8'(valid_a), 8'h00);
        rst = 1'b0;
        step();
        check("mid_after_gnt", 8'(gnt_a), 8'h01);
        check("mid_after_idx", 8'(idx_a), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
